// File: rtl/locking_rr_arbiter_n_pkg.sv
// Shared definitions for the locking round-robin Acquire arbiter:
// a_type encodings, default field widths and a constant clog2 helper.
package locking_rr_arbiter_n_pkg;

  localparam int A_TYPE_W = 3;

  typedef enum logic [A_TYPE_W-1:0] {
    A_GET          = 3'd0,
    A_GET_BLOCK    = 3'd1,
    A_PUT          = 3'd2,
    A_PUT_BLOCK    = 3'd3,
    A_PUT_ATOMIC   = 3'd4,
    A_GET_PREFETCH = 3'd5,
    A_PUT_PREFETCH = 3'd6
  } a_type_e;

  localparam int DEF_N_IN    = 4;
  localparam int DEF_BEATS   = 8;
  localparam int DEF_ADDR_W  = 26;
  localparam int DEF_XID_W   = 2;
  localparam int DEF_BEAT_W  = 3;
  localparam int DEF_UNION_W = 12;
  localparam int DEF_DATA_W  = 64;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/locking_rr_arbiter_n_pick.sv
// Combinational round-robin pick: lowest valid index above last_grant,
// else lowest valid index, else N_IN-1 when nothing is valid.
module rr_pick_n
  import locking_rr_arbiter_n_pkg::*;
#(
  parameter int N_IN = DEF_N_IN,
  parameter int CH_W = (N_IN > 1) ? clog2_f(N_IN) : 1
) (
  input  logic [N_IN-1:0] i_valid,
  input  logic [CH_W-1:0] i_last_grant,
  output logic [CH_W-1:0] o_choice,
  output logic            o_any_valid
);

  logic [CH_W-1:0] w_lo_any;
  logic [CH_W-1:0] w_lo_above;
  logic            w_has_above;

  // Scanning downwards lets the last assignment be the lowest matching index.
  always_comb begin
    w_lo_any    = CH_W'(N_IN - 1);
    w_lo_above  = '0;
    w_has_above = 1'b0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (i_valid[i]) begin
        w_lo_any = CH_W'(i);
        if (i > int'(i_last_grant)) begin
          w_lo_above  = CH_W'(i);
          w_has_above = 1'b1;
        end
      end
    end
  end

  assign o_choice    = w_has_above ? w_lo_above : w_lo_any;
  assign o_any_valid = |i_valid;

endmodule

// File: rtl/locking_rr_arbiter_n.sv
// N-input round-robin Acquire arbiter that locks onto an input for a full
// put-block burst. Define LOCKING_RR_ARB_WDOG_EN to add the lock-stall watchdog.
module locking_rr_arbiter_n
  import locking_rr_arbiter_n_pkg::*;
#(
  parameter int N_IN      = DEF_N_IN,
  parameter int BEATS     = DEF_BEATS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int XID_W     = DEF_XID_W,
  parameter int BEAT_W    = DEF_BEAT_W,
  parameter int UNION_W   = DEF_UNION_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LOCK_TYPE = int'(A_PUT_BLOCK),
`ifdef LOCKING_RR_ARB_WDOG_EN
  parameter int WDOG_CYCLES = 256,
`endif
  localparam int CH_W = (N_IN > 1) ? clog2_f(N_IN) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_IN-1:0]          io_in_valid,
  output logic [N_IN-1:0]          io_in_ready,
  input  logic [N_IN*ADDR_W-1:0]   io_in_bits_addr_block,
  input  logic [N_IN*XID_W-1:0]    io_in_bits_client_xact_id,
  input  logic [N_IN*BEAT_W-1:0]   io_in_bits_addr_beat,
  input  logic [N_IN-1:0]          io_in_bits_is_builtin_type,
  input  logic [N_IN*A_TYPE_W-1:0] io_in_bits_a_type,
  input  logic [N_IN*UNION_W-1:0]  io_in_bits_union,
  input  logic [N_IN*DATA_W-1:0]   io_in_bits_data,
  input  logic                     io_out_ready,
  output logic                     io_out_valid,
  output logic [ADDR_W-1:0]        io_out_bits_addr_block,
  output logic [XID_W-1:0]         io_out_bits_client_xact_id,
  output logic [BEAT_W-1:0]        io_out_bits_addr_beat,
  output logic                     io_out_bits_is_builtin_type,
  output logic [A_TYPE_W-1:0]      io_out_bits_a_type,
  output logic [UNION_W-1:0]       io_out_bits_union,
  output logic [DATA_W-1:0]        io_out_bits_data,
  output logic [CH_W-1:0]          io_chosen,
`ifdef LOCKING_RR_ARB_WDOG_EN
  output logic                     io_wdog_err,
`endif
  output logic                     io_locked
);

  logic [BEAT_W-1:0] r_beat_cnt;
  logic [CH_W-1:0]   r_lock_idx;
  logic [CH_W-1:0]   r_last_grant;

  logic [CH_W-1:0]   w_choice;
  logic [CH_W-1:0]   w_chosen;
  logic              w_any_valid;
  logic              w_locked;
  logic              w_fire;
  logic              w_lock_beat;

  logic [ADDR_W-1:0]   w_addr  [N_IN];
  logic [XID_W-1:0]    w_xid   [N_IN];
  logic [BEAT_W-1:0]   w_beat  [N_IN];
  logic [A_TYPE_W-1:0] w_atype [N_IN];
  logic [UNION_W-1:0]  w_union [N_IN];
  logic [DATA_W-1:0]   w_data  [N_IN];

  rr_pick_n #(
    .N_IN (N_IN),
    .CH_W (CH_W)
  ) u_pick (
    .i_valid      (io_in_valid),
    .i_last_grant (r_last_grant),
    .o_choice     (w_choice),
    .o_any_valid  (w_any_valid)
  );

  assign w_locked  = (r_beat_cnt != '0);
  assign io_locked = w_locked;
  assign w_chosen  = w_locked ? r_lock_idx : w_choice;
  assign io_chosen = w_chosen;

  // Unflatten the packed input buses so the output mux is a plain array index.
  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_in
      assign w_addr[gi]      = io_in_bits_addr_block[gi*ADDR_W +: ADDR_W];
      assign w_xid[gi]       = io_in_bits_client_xact_id[gi*XID_W +: XID_W];
      assign w_beat[gi]      = io_in_bits_addr_beat[gi*BEAT_W +: BEAT_W];
      assign w_atype[gi]     = io_in_bits_a_type[gi*A_TYPE_W +: A_TYPE_W];
      assign w_union[gi]     = io_in_bits_union[gi*UNION_W +: UNION_W];
      assign w_data[gi]      = io_in_bits_data[gi*DATA_W +: DATA_W];
      assign io_in_ready[gi] = io_out_ready & (w_chosen == CH_W'(gi));
    end
  endgenerate

  // While locked the granted input may be idle; no other input steals the slot.
  assign io_out_valid = w_locked ? io_in_valid[r_lock_idx] : w_any_valid;

  assign io_out_bits_addr_block      = w_addr[w_chosen];
  assign io_out_bits_client_xact_id  = w_xid[w_chosen];
  assign io_out_bits_addr_beat       = w_beat[w_chosen];
  assign io_out_bits_is_builtin_type = io_in_bits_is_builtin_type[w_chosen];
  assign io_out_bits_a_type          = w_atype[w_chosen];
  assign io_out_bits_union           = w_union[w_chosen];
  assign io_out_bits_data            = w_data[w_chosen];

  assign w_fire      = io_out_ready & io_out_valid;
  assign w_lock_beat = w_fire & io_out_bits_is_builtin_type &
                       (io_out_bits_a_type == A_TYPE_W'(LOCK_TYPE));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat_cnt   <= '0;
      r_lock_idx   <= '0;
      r_last_grant <= CH_W'(N_IN - 1);
    end else begin
      if (w_fire) begin
        r_last_grant <= w_chosen;
      end
      if (w_lock_beat) begin
        r_beat_cnt <= (r_beat_cnt == BEAT_W'(BEATS - 1)) ? '0 : r_beat_cnt + 1'b1;
        r_lock_idx <= w_chosen;
      end
    end
  end

`ifdef LOCKING_RR_ARB_WDOG_EN
  localparam int WD_W = clog2_f(WDOG_CYCLES) + 1;

  logic [WD_W-1:0] r_wdog_cnt;
  logic [WD_W-1:0] w_wdog_cnt_next;
  logic            r_wdog_err;

  // Counts idle cycles of the locked input; saturates at the threshold.
  always_comb begin
    w_wdog_cnt_next = r_wdog_cnt;
    if (!w_locked || w_fire) begin
      w_wdog_cnt_next = '0;
    end else if (!io_in_valid[r_lock_idx] && (r_wdog_cnt != WD_W'(WDOG_CYCLES))) begin
      w_wdog_cnt_next = r_wdog_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wdog_cnt <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      r_wdog_cnt <= w_wdog_cnt_next;
      if (w_wdog_cnt_next == WD_W'(WDOG_CYCLES)) begin
        r_wdog_err <= 1'b1;
      end
    end
  end

  assign io_wdog_err = r_wdog_err;
`endif

endmodule

// File: tb/tb_locking_rr_arbiter_n.sv
// Scoreboard bench for locking_rr_arbiter_n (4 inputs, 8 beats); expected
// {chosen, valid, locked, ready} tuples are queued at drive time and popped at negedge.
module tb_locking_rr_arbiter_n;

  localparam int N  = 4;
  localparam int AW = 26;
  localparam int XW = 2;
  localparam int BW = 3;
  localparam int UW = 12;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    io_in_valid = '0;
  logic [N-1:0]    io_in_ready;
  logic [N*AW-1:0] in_addr = '0;
  logic [N*XW-1:0] in_xid = '0;
  logic [N*BW-1:0] in_beat = '0;
  logic [N-1:0]    in_builtin = '0;
  logic [N*3-1:0]  in_atype = '0;
  logic [N*UW-1:0] in_union = '0;
  logic [N*DW-1:0] in_data = '0;
  logic            io_out_ready = 1'b0;
  logic            io_out_valid;
  logic [AW-1:0]   out_addr;
  logic [XW-1:0]   out_xid;
  logic [BW-1:0]   out_beat;
  logic            out_builtin;
  logic [2:0]      out_atype;
  logic [UW-1:0]   out_union;
  logic [DW-1:0]   out_data;
  logic [1:0]      io_chosen;
  logic            io_locked;
`ifdef LOCKING_RR_ARB_WDOG_EN
  logic            io_wdog_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] sb[$];
  logic [0:0] sb_err[$];

  locking_rr_arbiter_n #(
    .N_IN (4)
`ifdef LOCKING_RR_ARB_WDOG_EN
    , .WDOG_CYCLES (16)
`endif
  ) dut (
    .clk                         (clk),
    .reset                       (reset),
    .io_in_valid                 (io_in_valid),
    .io_in_ready                 (io_in_ready),
    .io_in_bits_addr_block       (in_addr),
    .io_in_bits_client_xact_id   (in_xid),
    .io_in_bits_addr_beat        (in_beat),
    .io_in_bits_is_builtin_type  (in_builtin),
    .io_in_bits_a_type           (in_atype),
    .io_in_bits_union            (in_union),
    .io_in_bits_data             (in_data),
    .io_out_ready                (io_out_ready),
    .io_out_valid                (io_out_valid),
    .io_out_bits_addr_block      (out_addr),
    .io_out_bits_client_xact_id  (out_xid),
    .io_out_bits_addr_beat       (out_beat),
    .io_out_bits_is_builtin_type (out_builtin),
    .io_out_bits_a_type          (out_atype),
    .io_out_bits_union           (out_union),
    .io_out_bits_data            (out_data),
    .io_chosen                   (io_chosen),
`ifdef LOCKING_RR_ARB_WDOG_EN
    .io_wdog_err                 (io_wdog_err),
`endif
    .io_locked                   (io_locked)
  );

  always #5 clk = ~clk;

  // Expected {chosen, out_valid, locked, in_ready} from the arbitration rules.
  function automatic logic [7:0] pack_exp(input int ch, input logic ov, input logic lk,
                                          input logic rdy);
    logic [3:0] one;
    one = 4'b0001;
    return {2'(ch), ov, lk, rdy ? (one << ch) : 4'b0000};
  endfunction

  task automatic set_type(input int i, input logic [2:0] t, input logic b);
    in_atype[i*3 +: 3] = t;
    in_builtin[i]      = b;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    logic [7:0] got;
    reset = 1'b1;
    io_in_valid = '0;
    io_out_ready = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    sb.push_back(pack_exp(3, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    e = sb.pop_front();
    got = {io_chosen, io_out_valid, io_locked, io_in_ready};
    n_checks++;
    if (got !== e) $display("FAIL reset_idle got=%b exp=%b", got, e);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [7:0]  e;
    logic [7:0]  got;
    logic [63:0] ed;
    io_in_valid = 4'b1111;
    io_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sb.push_back(pack_exp(k % 4, 1'b1, 1'b0, 1'b1));
      ed = 64'hD000_0000_0000_0000 + 64'(k % 4);
      @(negedge clk);
      e = sb.pop_front();
      got = {io_chosen, io_out_valid, io_locked, io_in_ready};
      n_checks++;
      if (got !== e) $display("FAIL rr k=%0d got=%b exp=%b", k, got, e);
      else n_pass++;
      n_checks++;
      if (out_data !== ed) $display("FAIL rr_data k=%0d got=%h exp=%h", k, out_data, ed);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_wrap();
    logic [7:0] e;
    logic [7:0] got;
    logic [3:0] vld [3] = '{4'b0100, 4'b0011, 4'b0011};
    int         ch  [3] = '{2, 0, 1};
    for (int k = 0; k < 3; k++) begin
      io_in_valid = vld[k];
      sb.push_back(pack_exp(ch[k], 1'b1, 1'b0, 1'b1));
      @(negedge clk);
      e = sb.pop_front();
      got = {io_chosen, io_out_valid, io_locked, io_in_ready};
      n_checks++;
      if (got !== e) $display("FAIL wrap k=%0d got=%b exp=%b", k, got, e);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_hold();
    logic [7:0] e;
    logic [7:0] got;
    logic [3:0] vld [4] = '{4'b1111, 4'b1111, 4'b0011, 4'b1111};
    logic       rdy [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int         ch  [4] = '{2, 2, 0, 2};
    for (int k = 0; k < 4; k++) begin
      io_in_valid = vld[k];
      io_out_ready = rdy[k];
      sb.push_back(pack_exp(ch[k], 1'b1, 1'b0, rdy[k]));
      @(negedge clk);
      e = sb.pop_front();
      got = {io_chosen, io_out_valid, io_locked, io_in_ready};
      n_checks++;
      if (got !== e) $display("FAIL hold k=%0d got=%b exp=%b", k, got, e);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_lock_burst();
    logic [7:0] e;
    logic [7:0] got;
    set_type(1, 3'd3, 1'b1);
    io_in_valid = 4'b0110;
    io_out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      sb.push_back(pack_exp((k == 8) ? 2 : 1, 1'b1, (k > 0 && k < 8), 1'b1));
      @(negedge clk);
      e = sb.pop_front();
      got = {io_chosen, io_out_valid, io_locked, io_in_ready};
      n_checks++;
      if (got !== e) $display("FAIL lock_burst k=%0d got=%b exp=%b", k, got, e);
      else n_pass++;
      next_cycle();
    end
    set_type(1, 3'd0, 1'b0);
  endtask

  task automatic test_lock_stall();
    logic [7:0] e;
    logic [7:0] got;
    set_type(3, 3'd3, 1'b1);
    io_out_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      if (k < 2) begin
        io_in_valid = 4'b1111;
        sb.push_back(pack_exp(3, 1'b1, k > 0, 1'b1));
      end else if (k < 7) begin
        io_in_valid = 4'b0111;
        sb.push_back(pack_exp(3, 1'b0, 1'b1, 1'b1));
      end else if (k < 13) begin
        io_in_valid = 4'b1111;
        sb.push_back(pack_exp(3, 1'b1, 1'b1, 1'b1));
      end else begin
        io_in_valid = 4'b1111;
        sb.push_back(pack_exp(0, 1'b1, 1'b0, 1'b1));
      end
      @(negedge clk);
      e = sb.pop_front();
      got = {io_chosen, io_out_valid, io_locked, io_in_ready};
      n_checks++;
      if (got !== e) $display("FAIL lock_stall k=%0d got=%b exp=%b", k, got, e);
      else n_pass++;
      next_cycle();
    end
    set_type(3, 3'd0, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] e;
    logic [7:0] got;
    set_type(1, 3'd3, 1'b1);
    io_in_valid = 4'b0010;
    io_out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 4) reset = 1'b1;
      if (k == 5) begin
        reset = 1'b0;
        io_in_valid = 4'b1111;
        set_type(1, 3'd0, 1'b0);
      end
      if (k < 5)       sb.push_back(pack_exp(1, 1'b1, k > 0, 1'b1));
      else if (k == 5) sb.push_back(pack_exp(0, 1'b1, 1'b0, 1'b1));
      else             sb.push_back(pack_exp(1, 1'b1, 1'b0, 1'b1));
      @(negedge clk);
      e = sb.pop_front();
      got = {io_chosen, io_out_valid, io_locked, io_in_ready};
      n_checks++;
      if (got !== e) $display("FAIL reset_mid k=%0d got=%b exp=%b", k, got, e);
      else n_pass++;
      next_cycle();
    end
  endtask

`ifdef LOCKING_RR_ARB_WDOG_EN
  task automatic test_wdog();
    logic [0:0] e;
    reset = 1'b1;
    io_in_valid = '0;
    next_cycle();
    reset = 1'b0;
    set_type(0, 3'd3, 1'b1);
    io_out_ready = 1'b1;
    // c0 beat1, c1..c15 idle, c16 beat2, c17..c32 idle, c33..c35 beats.
    for (int c = 0; c < 36; c++) begin
      io_in_valid = (c == 0 || c == 16 || c >= 33) ? 4'b0001 : 4'b0000;
      sb_err.push_back((c >= 33) ? 1'b1 : 1'b0);
      @(negedge clk);
      e = sb_err.pop_front();
      n_checks++;
      if (io_wdog_err !== e[0]) $display("FAIL wdog c=%0d got=%b exp=%b", c, io_wdog_err, e[0]);
      else n_pass++;
      next_cycle();
    end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    set_type(0, 3'd0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (io_wdog_err !== 1'b0) $display("FAIL wdog_reset got=%b exp=0", io_wdog_err);
    else n_pass++;
    next_cycle();
  endtask
`endif

  initial begin
    for (int i = 0; i < N; i++) begin
      in_addr[i*AW +: AW]  = AW'(32'h100 + i);
      in_xid[i*XW +: XW]   = XW'(i);
      in_union[i*UW +: UW] = UW'(32'hA0 + i);
      in_data[i*DW +: DW]  = 64'hD000_0000_0000_0000 + 64'(i);
    end
    test_reset();
    test_round_robin();
    test_wrap();
    test_hold();
    test_lock_burst();
    test_lock_stall();
    test_reset_mid_burst();
`ifdef LOCKING_RR_ARB_WDOG_EN
    test_wdog();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not finish got=running exp=done");
    $fatal(1, "timeout");
  end

endmodule
